rom_read_arbiter: RTL and testbench

- Shares the single-port synchronous instruction/data ROM between two requesters: port A (instruction fetch) and port B (data load).
- Arbitrates one read per cycle using round-robin priority.
- Issues pipelined reads and tracks in-flight ownership through the ROM read latency.
- Routes each returned word to the requester that issued it.
- Sits between the CPU fetch/memory stages and the ROM instance.

---
 rtl/rom_read_arbiter.sv | 115 +++++++++++
 tb/tb_rom_read_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous ROM between an
// instruction-fetch port (A) and a data-load port (B), routing pipelined reads back to their owner.
module rom_read_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_gnt,
    output logic          b_rvalid,
    input  logic          flush_a,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rom_address,
    input  logic [DW-1:0] rom_q,
    output logic          busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("rom_read_arbiter: READ_LATENCY must be in 1..4");
    end

    localparam int unsigned L    = READ_LATENCY;
    localparam int unsigned Last = READ_LATENCY - 1;

    typedef enum logic {
        PrioA = 1'b0,
        PrioB = 1'b1
    } prio_e;

    prio_e         prio_q, prio_d;
    logic [AW-1:0] addr_q, addr_d;
    // Per-stage in-flight tracking; own bit is 1 when the read belongs to port B.
    logic [L-1:0]  vld_q, vld_d;
    logic [L-1:0]  own_q, own_d;
    logic          any_gnt;

    // Grant: a lone requester always wins; on conflict the pointer decides.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_req && (!b_req || prio_q == PrioA)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = a_gnt | b_gnt;

    always_comb begin
        prio_d = prio_q;
        if (a_gnt) begin
            prio_d = PrioB;
        end else if (b_gnt) begin
            prio_d = PrioA;
        end
    end

    // Held address keeps the ROM address bus quiet on idle cycles.
    always_comb begin
        if (a_gnt) begin
            rom_address = a_addr;
        end else if (b_gnt) begin
            rom_address = b_addr;
        end else begin
            rom_address = addr_q;
        end
    end

    assign addr_d = any_gnt ? rom_address : addr_q;

    // A grant issued alongside flush_a enters stage 0 unflushed; older A reads are dropped.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = any_gnt;
        own_d[0] = b_gnt;
        for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1] & ~(flush_a & ~own_q[i-1]);
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PrioA;
            addr_q <= '0;
            vld_q  <= '0;
            own_q  <= '0;
        end else begin
            prio_q <= prio_d;
            addr_q <= addr_d;
            vld_q  <= vld_d;
            own_q  <= own_d;
        end
    end

    // flush_a also squashes an A word returning this very cycle: the fetch it answers is stale.
    always_comb begin
        a_rvalid = vld_q[Last] & ~own_q[Last] & ~flush_a;
        b_rvalid = vld_q[Last] & own_q[Last];
        rsp_data = rom_q;
        busy     = |vld_q;
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed self-checking bench for rom_read_arbiter with READ_LATENCY=2 and a ROM model
// that returns addr+16'h1000 two clocks after the address is presented.
module tb_rom_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, b_req, flush_a;
    logic [15:0] a_addr, b_addr;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
    logic [15:0] rsp_data, rom_address, rom_q;
    logic [15:0] rom_addr_r;

    int n_cmp = 0;
    int n_err = 0;

    rom_read_arbiter #(
        .AW          (16),
        .DW          (16),
        .READ_LATENCY(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_req      (a_req),
        .a_addr     (a_addr),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .b_req      (b_req),
        .b_addr     (b_addr),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .flush_a    (flush_a),
        .rsp_data   (rsp_data),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-address, registered-output ROM.
    initial begin
        rom_addr_r = '0;
        rom_q      = '0;
    end
    always @(posedge clk) begin
        rom_addr_r <= rom_address;
        rom_q      <= rom_addr_r + 16'h1000;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, leave time to settle before checks.
    task automatic cyc(input logic ar, input logic [15:0] aa, input logic br,
                       input logic [15:0] ba, input logic fl);
        @(posedge clk);
        #1;
        a_req   = ar;
        a_addr  = aa;
        b_req   = br;
        b_addr  = ba;
        flush_a = fl;
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        flush_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] exp_d [6];
    logic        exp_b [6];

    initial begin
        rst_n   = 1'b0;
        a_req   = 1'b1;
        a_addr  = 16'h0abc;
        b_req   = 1'b1;
        b_addr  = 16'h0def;
        flush_a = 1'b0;
        #3;
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_rom_address", 32'(rom_address), 32'h0);
        do_reset();

        // Single A read
        cyc(1'b1, 16'h0005, 1'b0, 16'h0, 1'b0);
        check("t1_a_gnt", 32'(a_gnt), 32'd1);
        check("t1_rom_address", 32'(rom_address), 32'h0005);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        check("t1_hold_address", 32'(rom_address), 32'h0005);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_early_rvalid", 32'(a_rvalid), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        check("t1_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t1_b_rvalid", 32'(b_rvalid), 32'd0);
        check("t1_data", 32'(rsp_data), 32'h1005);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0);
        check("t1_a_rvalid_off", 32'(a_rvalid), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // Conflict after reset: A first, then B
        do_reset();
        cyc(1'b1, 16'h0003, 1'b1, 16'h0009, 1'b0);
        check("t2_c0_a_gnt", 32'(a_gnt), 32'd1);
        check("t2_c0_b_gnt", 32'(b_gnt), 32'd0);
        check("t2_c0_rom_address", 32'(rom_address), 32'h0003);
        cyc(1'b0, 16'h0003, 1'b1, 16'h0009, 1'b0);
        check("t2_c1_b_gnt", 32'(b_gnt), 32'd1);
        check("t2_c1_rom_address", 32'(rom_address), 32'h0009);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t2_c2_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t2_c2_data", 32'(rsp_data), 32'h1003);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t2_c3_b_rvalid", 32'(b_rvalid), 32'd1);
        check("t2_c3_a_rvalid", 32'(a_rvalid), 32'd0);
        check("t2_c3_data", 32'(rsp_data), 32'h1009);

        // Continuous contention: the loser holds its address until granted
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                cyc(1'b1, 16'h0020 + 16'((k + 1) / 2), 1'b1, 16'h0040 + 16'(k / 2), 1'b0);
                check("t3_a_gnt", 32'(a_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
                check("t3_b_gnt", 32'(b_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
                exp_b[k] = (k % 2 != 0);
                exp_d[k] = (k % 2 == 0) ? 16'h1020 + 16'(k / 2) : 16'h1040 + 16'(k / 2);
            end else begin
                cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
            end
            if (k >= 2) begin
                check("t3_a_rvalid", 32'(a_rvalid), 32'(!exp_b[k-2]));
                check("t3_b_rvalid", 32'(b_rvalid), 32'(exp_b[k-2]));
                check("t3_data", 32'(rsp_data), 32'(exp_d[k-2]));
            end
        end

        // Flush: A reads at 1 and 2 dropped, concurrent B read survives
        cyc(1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0);
        check("t4_a1_gnt", 32'(a_gnt), 32'd1);
        cyc(1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0);
        check("t4_a2_gnt", 32'(a_gnt), 32'd1);
        cyc(1'b0, 16'h0000, 1'b1, 16'h0033, 1'b1);
        check("t4_b_gnt", 32'(b_gnt), 32'd1);
        check("t4_a1_dropped", 32'(a_rvalid), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t4_a2_dropped", 32'(a_rvalid), 32'd0);
        check("t4_no_b_yet", 32'(b_rvalid), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t4_b_rvalid", 32'(b_rvalid), 32'd1);
        check("t4_a_rvalid", 32'(a_rvalid), 32'd0);
        check("t4_b_data", 32'(rsp_data), 32'h1033);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t4_idle_busy", 32'(busy), 32'd0);

        // Flush in the same cycle as an A grant
        cyc(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 16'h0007, 1'b0, 16'h0000, 1'b1);
        check("t5_a7_gnt", 32'(a_gnt), 32'd1);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t5_a5_dropped", 32'(a_rvalid), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t5_a7_rvalid", 32'(a_rvalid), 32'd1);
        check("t5_a7_data", 32'(rsp_data), 32'h1007);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("t5_flush_idle", 32'(busy), 32'd0);

        // Reset with two reads in flight; pointer left at B beforehand
        cyc(1'b0, 16'h0000, 1'b1, 16'h0022, 1'b0);
        check("t6_b_gnt", 32'(b_gnt), 32'd1);
        cyc(1'b1, 16'h0011, 1'b0, 16'h0000, 1'b0);
        check("t6_a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk);
        #1;
        a_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("t6_rst_a_rvalid", 32'(a_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
            check("t6_post_a_rvalid", 32'(a_rvalid), 32'd0);
            check("t6_post_b_rvalid", 32'(b_rvalid), 32'd0);
            check("t6_post_busy", 32'(busy), 32'd0);
        end
        cyc(1'b1, 16'h0044, 1'b1, 16'h0055, 1'b0);
        check("t6_conflict_a_gnt", 32'(a_gnt), 32'd1);
        check("t6_conflict_b_gnt", 32'(b_gnt), 32'd0);
        cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
